// File: rtl/mul_ctrl.sv
// Execute-stage sequencer for AArch64 multiply-accumulate instructions.
// Latches and extends operands, drives the iterative multiplier core and produces a one-cycle result.
module mul_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   input  logic        flush,
   input  logic [2:0]  op,
   input  logic        sf,
   input  logic [63:0] rn,
   input  logic [63:0] rm,
   input  logic [63:0] ra,
   output logic        stall,
   output logic        out_valid,
   output logic [63:0] result,
   output logic        core_valid,
   output logic [63:0] core_a,
   output logic [63:0] core_b,
   input  logic        core_done,
   input  logic [63:0] core_c
);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_FIN, S_DRAIN
   } state_t;

   state_t      state, state_nxt;
   logic [2:0]  op_q;
   logic        sf_q;
   logic [63:0] ra_q, a_q, b_q, prod_q, res_hold;
   logic [63:0] a_ext, b_ext, sum, fin_res;
   logic        accept, reserved_in, fast;

   always_comb begin
      a_ext = {32'b0, rn[31:0]};
      b_ext = {32'b0, rm[31:0]};
      case (op)
         3'd0, 3'd1: if (sf) begin
            a_ext = rn;
            b_ext = rm;
         end
         3'd2, 3'd3: begin
            a_ext = {{32{rn[31]}}, rn[31:0]};
            b_ext = {{32{rm[31]}}, rm[31:0]};
         end
         default: ;
      endcase
   end

   assign accept      = (state == S_IDLE) && in_valid && !flush;
   assign reserved_in = op[2] & op[1];
   // A zero operand (or a reserved op) needs no core pass: product is known to be 0.
   assign fast        = reserved_in || (a_ext == 64'd0) || (b_ext == 64'd0);

   always_ff @(posedge clk) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (accept) state_nxt = fast ? S_FIN : S_ISSUE;
         S_ISSUE:   state_nxt = flush ? S_DRAIN : S_WAIT;
         S_WAIT:    if (flush) state_nxt = S_DRAIN;
                    else if (core_done) state_nxt = S_CAPTURE;
         S_CAPTURE: state_nxt = flush ? S_IDLE : S_FIN;
         S_FIN:     state_nxt = S_IDLE;
         S_DRAIN:   if (core_done) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      core_valid = (state == S_ISSUE);
      out_valid  = (state == S_FIN) && !flush;
      stall      = accept || (state == S_ISSUE) || (state == S_WAIT) ||
                   (state == S_CAPTURE) || ((state == S_DRAIN) && in_valid);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         op_q     <= 3'd0;
         sf_q     <= 1'b0;
         ra_q     <= 64'd0;
         a_q      <= 64'd0;
         b_q      <= 64'd0;
         prod_q   <= 64'd0;
         res_hold <= 64'd0;
      end else begin
         if (accept) begin
            op_q <= op;
            sf_q <= sf;
            ra_q <= ra;
            a_q  <= a_ext;
            b_q  <= b_ext;
            if (fast) prod_q <= 64'd0;
         end
         if (state == S_CAPTURE) prod_q <= core_c;
         if (out_valid) res_hold <= fin_res;
      end
   end

   // Odd ops are the subtracting forms; only 32-bit MADD/MSUB truncate.
   always_comb begin
      sum = op_q[0] ? (ra_q - prod_q) : (ra_q + prod_q);
      if (op_q[2] & op_q[1])
         fin_res = 64'd0;
      else if ((op_q[2:1] == 2'b00) && !sf_q)
         fin_res = {32'b0, sum[31:0]};
      else
         fin_res = sum;
   end

   assign result = out_valid ? fin_res : res_hold;
   assign core_a = a_q;
   assign core_b = b_q;

endmodule
